uart_rx_bit_timer: RTL and testbench

//  - Parametrised oversampling timer for the UART receiver; the RX FSM and data sampler consume its outputs.
//  - Counts oversample edges per bit and bits per frame for any legal prescale, not only 8 or 16.
//  - Decodes per-bit sample strobes plus bit-end and frame-end pulses.
//  - Freezes its configuration for the duration of a frame.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_bit_timer.sv | 114 +++++++++++
 tb/tb_uart_rx_bit_timer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and helpers for the UART receiver timing path
package uart_rx_pkg;

    localparam int PRESCALE_MIN       = 4;
    localparam int PRESCALE_WIDTH_DEF = 6;
    localparam int BIT_CNT_WIDTH_DEF  = 4;

    // Centre-of-bit edge index; floor for odd prescale so the data sampler
    // and the bit timer agree on the same sample point.
    function automatic int unsigned mid_point(input int unsigned prescale);
        return prescale >> 1;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - oversampling bit/frame timer for the UART receiver
//
// Counts oversample edges within a bit and bits within a frame, and decodes
// sample strobes plus bit-end / frame-end pulses. Prescale and frame length are
// captured into shadow registers while idle and frozen for the whole frame.
//
// Optional build macro: UART_RX_TRIPLE_SAMPLE_EN enables sample_pre/sample_post
// decode for majority voting; without it both are tied 0.
//
// Ports:
//   CLK_edge_bit  oversample clock (prescale x baud)
//   RST_edge_bit  asynchronous active-low reset
//   enable        count enable from the RX FSM; low = idle / clear counters
//   prescale      clocks per bit (legal 4..2^PRESCALE_WIDTH-1)
//   frame_bits    bits per frame (legal 1..2^BIT_CNT_WIDTH-1)
//   edge_cnt      edge position within the current bit
//   bit_cnt       bit index within the frame
//   sample_mid    centre-of-bit strobe
//   sample_pre    strobe one edge before centre
//   sample_post   strobe one edge after centre
//   bit_done      last edge of the current bit
//   frame_done    last edge of the last bit of the frame
//   cfg_err       shadowed configuration is illegal
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int BIT_CNT_WIDTH  = BIT_CNT_WIDTH_DEF
) (
    input  logic                      CLK_edge_bit,
    input  logic                      RST_edge_bit,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [BIT_CNT_WIDTH-1:0]  frame_bits,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      sample_mid,
    output logic                      sample_pre,
    output logic                      sample_post,
    output logic                      bit_done,
    output logic                      frame_done,
    output logic                      cfg_err
);

    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [BIT_CNT_WIDTH-1:0]  frame_bits_q, frame_bits_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;

    logic [PRESCALE_WIDTH-1:0] mid_edge;
    logic                      run;
    logic                      last_edge;
    logic                      last_bit;

    always_ff @(posedge CLK_edge_bit or negedge RST_edge_bit) begin
        if (!RST_edge_bit) begin
            prescale_q   <= '0;
            frame_bits_q <= '0;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
        end else begin
            prescale_q   <= prescale_d;
            frame_bits_q <= frame_bits_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    // Reset leaves the shadows at zero, so cfg_err reads 1 until the first
    // idle clock loads a real configuration.
    assign cfg_err   = (prescale_q < PRESCALE_WIDTH'(PRESCALE_MIN)) || (frame_bits_q == '0);
    assign run       = enable && !cfg_err;
    assign mid_edge  = PRESCALE_WIDTH'(mid_point(32'(prescale_q)));
    assign last_edge = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));
    assign last_bit  = (bit_cnt_q == frame_bits_q - BIT_CNT_WIDTH'(1));

    always_comb begin
        prescale_d   = prescale_q;
        frame_bits_d = frame_bits_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        if (!enable) begin
            prescale_d   = prescale;
            frame_bits_d = frame_bits;
            edge_cnt_d   = '0;
            bit_cnt_d    = '0;
        end else if (cfg_err) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (last_edge) begin
            edge_cnt_d = '0;
            // Wrap at the last bit so back-to-back frames need no idle cycle.
            bit_cnt_d  = last_bit ? '0 : bit_cnt_q + BIT_CNT_WIDTH'(1);
        end else begin
            edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    assign edge_cnt   = edge_cnt_q;
    assign bit_cnt    = bit_cnt_q;
    assign sample_mid = run && (edge_cnt_q == mid_edge);
    assign bit_done   = run && last_edge;
    assign frame_done = run && last_edge && last_bit;

`ifdef UART_RX_TRIPLE_SAMPLE_EN
    // mid_edge >= 2 whenever cfg is legal, so the -1 never underflows.
    assign sample_pre  = run && (edge_cnt_q == mid_edge - PRESCALE_WIDTH'(1));
    assign sample_post = run && (edge_cnt_q == mid_edge + PRESCALE_WIDTH'(1));
`else
    assign sample_pre  = 1'b0;
    assign sample_post = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb/tb_uart_rx_bit_timer.sv - directed self-checking bench for uart_rx_bit_timer
module tb_uart_rx_bit_timer;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic [5:0] prescale;
    logic [3:0] frame_bits;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_mid, sample_pre, sample_post, bit_done, frame_done, cfg_err;

    int passed = 0;
    int total  = 0;

`ifdef UART_RX_TRIPLE_SAMPLE_EN
    localparam bit TRIPLE = 1'b1;
`else
    localparam bit TRIPLE = 1'b0;
`endif

    uart_rx_bit_timer dut (
        .CLK_edge_bit (clk),
        .RST_edge_bit (rstn),
        .enable       (enable),
        .prescale     (prescale),
        .frame_bits   (frame_bits),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sample_mid   (sample_mid),
        .sample_pre   (sample_pre),
        .sample_post  (sample_post),
        .bit_done     (bit_done),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {edge_cnt, bit_cnt, pre, mid, post, bit_done, frame_done}
    function automatic logic [14:0] obs_vec();
        return {edge_cnt, bit_cnt, sample_pre, sample_mid, sample_post, bit_done, frame_done};
    endfunction

    // Expected outputs for enabled cycle c of a continuous run with prescale p, frame f.
    function automatic logic [14:0] exp_vec(input int c, input int p, input int f);
        int e, b, m;
        e = c % p;
        b = (c / p) % f;
        m = p / 2;
        return {6'(e), 4'(b), TRIPLE && (e == m - 1), e == m, TRIPLE && (e == m + 1),
                e == p - 1, (e == p - 1) && (b == f - 1)};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_cfg(input int p, input int f);
        enable     = 1'b0;
        prescale   = 6'(p);
        frame_bits = 4'(f);
        step();
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; prescale = 6'd8; frame_bits = 4'd10;
        step();
        total++;
        if ({obs_vec(), cfg_err} !== {15'd0, 1'b1})
            $display("FAIL reset_state got=%h exp=%h", {obs_vec(), cfg_err}, {15'd0, 1'b1});
        else passed++;
        rstn = 1'b1;
        step();
        total++;
        if (cfg_err !== 1'b0) $display("FAIL shadow_load cfg_err got=%b exp=0", cfg_err);
        else passed++;
    endtask

    task automatic test_p8_f10();
        logic [14:0] o;
        load_cfg(8, 10);
        enable = 1'b1;
        #1;
        for (int c = 0; c <= 80; c++) begin
            o = obs_vec();
            total++;
            if (o !== exp_vec(c, 8, 10))
                $display("FAIL p8f10 cycle=%0d got=%h exp=%h", c, o, exp_vec(c, 8, 10));
            else passed++;
            step();
        end
    endtask

    task automatic test_p16_f11_back_to_back();
        logic [14:0] o;
        load_cfg(16, 11);
        enable = 1'b1;
        #1;
        for (int c = 0; c < 2 * 176; c++) begin
            o = obs_vec();
            total++;
            if (o !== exp_vec(c, 16, 11))
                $display("FAIL p16f11 cycle=%0d got=%h exp=%h", c, o, exp_vec(c, 16, 11));
            else passed++;
            step();
        end
    endtask

    task automatic test_p5_f2();
        logic [14:0] o;
        load_cfg(5, 2);
        enable = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            o = obs_vec();
            total++;
            if (o !== exp_vec(c, 5, 2))
                $display("FAIL p5f2 cycle=%0d got=%h exp=%h", c, o, exp_vec(c, 5, 2));
            else passed++;
            step();
        end
    endtask

    task automatic test_cfg_freeze();
        logic [14:0] o;
        load_cfg(8, 10);
        enable = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) prescale = 6'd16;
            o = obs_vec();
            total++;
            if (o !== exp_vec(c, 8, 10))
                $display("FAIL cfg_freeze cycle=%0d got=%h exp=%h", c, o, exp_vec(c, 8, 10));
            else passed++;
            step();
        end
        enable = 1'b0;
        step();
        enable = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            o = obs_vec();
            total++;
            if (o !== exp_vec(c, 16, 10))
                $display("FAIL cfg_reload cycle=%0d got=%h exp=%h", c, o, exp_vec(c, 16, 10));
            else passed++;
            step();
        end
        enable = 1'b0;
    endtask

    task automatic test_cfg_err();
        load_cfg(3, 10);
        total++;
        if (cfg_err !== 1'b1) $display("FAIL cfg_err_p3 got=%b exp=1", cfg_err);
        else passed++;
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (obs_vec() !== 15'd0) $display("FAIL cfg_err_p3_hold cycle=%0d got=%h exp=0", c, obs_vec());
            else passed++;
        end
        load_cfg(8, 0);
        total++;
        if (cfg_err !== 1'b1) $display("FAIL cfg_err_f0 got=%b exp=1", cfg_err);
        else passed++;
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (obs_vec() !== 15'd0) $display("FAIL cfg_err_f0_hold cycle=%0d got=%h exp=0", c, obs_vec());
            else passed++;
        end
        load_cfg(4, 1);
        total++;
        if (cfg_err !== 1'b0) $display("FAIL cfg_ok_p4 got=%b exp=0", cfg_err);
        else passed++;
    endtask

    task automatic test_abort_and_reset();
        logic [14:0] o;
        load_cfg(8, 10);
        enable = 1'b1;
        #1;
        for (int c = 0; c < 30; c++) begin
            o = obs_vec();
            total++;
            if (o !== exp_vec(c, 8, 10))
                $display("FAIL abort_run cycle=%0d got=%h exp=%h", c, o, exp_vec(c, 8, 10));
            else passed++;
            if (c < 29) step();
        end
        // now at bit_cnt=3, edge_cnt=5
        enable = 1'b0;
        step();
        total++;
        if ({edge_cnt, bit_cnt} !== 10'd0)
            $display("FAIL abort_clear got=%h exp=0", {edge_cnt, bit_cnt});
        else passed++;
        enable = 1'b1;
        #1;
        for (int c = 0; c < 21; c++) step();
        total++;
        if (obs_vec() !== exp_vec(21, 8, 10))
            $display("FAIL pre_reset got=%h exp=%h", obs_vec(), exp_vec(21, 8, 10));
        else passed++;
        rstn = 1'b0;
        #1;
        total++;
        if ({obs_vec(), cfg_err} !== {15'd0, 1'b1})
            $display("FAIL async_reset got=%h exp=%h", {obs_vec(), cfg_err}, {15'd0, 1'b1});
        else passed++;
        step();
        rstn = 1'b1;
        enable = 1'b0;
        step();
        total++;
        if (cfg_err !== 1'b0) $display("FAIL reload_after_reset got=%b exp=0", cfg_err);
        else passed++;
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; prescale = '0; frame_bits = '0;
        test_reset();
        test_p8_f10();
        test_p16_f11_back_to_back();
        test_p5_f2();
        test_cfg_freeze();
        test_cfg_err();
        test_abort_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
